d_sramlike_axi_bridge: RTL and testbench
========================================

// Module: d_sramlike_axi_bridge
// PURPOSE
//  Converts the data cache's SRAM-like miss/writeback port (req/wr/size/addr/wdata -> addr_ok/data_ok/rdata)
//  into a single-beat AXI master. Sits directly downstream of the write-back D-cache, upstream of the AXI crossbar.
//  One transaction outstanding at a time; every transfer is one beat (len=0), no bursts.
// PARAMETERS
//  ID_WIDTH   4   width of AXI id fields
//  AXI_ID     1   constant id driven on arid/awid
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   asynchronous active-high reset
//  req          in   1   cache request; held high until addr_ok
//  wr           in   1   1=write, 0=read
//  size         in   2   00 byte, 01 half, 10 word (11 treated as word)
//  addr         in   32  byte address
//  wdata        in   32  write data, byte lanes in place
//  rdata        out  32  read data, valid only when data_ok & ~wr_q
//  addr_ok      out  1   request accepted (AR or AW handshake this cycle)
//  data_ok      out  1   transaction complete (R or B handshake this cycle)
//  AR: arid[ID_WIDTH] araddr[32] arlen[8] arsize[3] arburst[2] arvalid out; arready in
//  R : rid[ID_WIDTH] rdata[32] rresp[2] rlast rvalid in; rready out
//  AW: awid awaddr[32] awlen[8] awsize[3] awburst[2] awvalid out; awready in
//  W : wdata_o[32] wstrb[4] wlast wvalid out; wready in
//  B : bid bresp[2] bvalid in; bready out
// BEHAVIOUR
//  - Reset (async): state=IDLE; arvalid, awvalid, wvalid, rready, bready, addr_ok, data_ok = 0; latches = 0.
//  - FSM: IDLE -> (req & ~wr) RD_ADDR | (req & wr) WR_ADDR; RD_ADDR -> RD_DATA on arvalid&arready;
//    RD_DATA -> IDLE on rvalid&rready; WR_ADDR -> WR_RESP when AW and W both handshaken (any order,
//    same or different cycles, tracked by aw_done/w_done flags); WR_RESP -> IDLE on bvalid&bready.
//  - Request latched (wr_q, size_q, addr_q, wdata_q) in IDLE when req=1; AXI fields driven from latches only.
//  - arvalid=1 only in RD_ADDR; awvalid=1 in WR_ADDR & ~aw_done; wvalid=1 in WR_ADDR & ~w_done.
//  - addr_ok = arvalid&arready (read) or completion cycle of the later of AW/W handshakes (write); one pulse per req.
//  - rready=1 only in RD_DATA; bready=1 only in WR_RESP. data_ok = rvalid&rready | bvalid&bready (combinational).
//  - rdata is combinational passthrough of AXI rdata; not registered.
//  - Fixed fields: arlen=awlen=0, arburst=awburst=2'b01 (INCR), wlast=1, arsize=awsize={1'b0,size_q} (11 -> 3'b010).
//  - wstrb: byte 0001<<addr_q[1:0]; half addr_q[1]?1100:0011; word 1111. wdata_o = wdata_q unshifted.
//  - Latency: req cycle 0 -> arvalid cycle 1; with arready=1 and rvalid next cycle, data_ok at cycle 2.
//  - rresp/bresp != OKAY: ignored, data_ok still pulses (no error path). rid/bid not checked.
//  - req while FSM not IDLE: ignored (cache holds req high until addr_ok; no second acceptance).
//  - rvalid/bvalid arriving in wrong state: not accepted (rready/bready low), no state change.
//  - Reset mid-transaction: FSM to IDLE immediately; pending AXI beat abandoned, no data_ok issued.
// STRUCTURE
//  - Shared package: AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR, SIZE_BYTE/HALF/WORD, state encodings,
//    function size_addr_to_strb(size, addr[1:0]) (also used by cache write-mask logic).
//  - Single module; no sub-module needed.
// TESTING
//  1 read word 0x1000_0004, arready=1, rvalid+rdata=0xDEADBEEF one cycle later -> addr_ok cycle 1, data_ok+rdata cycle 2.
//  2 write byte addr 0x...3 wdata 0xAA000000; awready early, wready 3 cycles later -> wstrb=1000, addr_ok on W hs, B -> data_ok.
//  3 write half addr 0x...2, AW and W ready same cycle -> wstrb=1100, awsize=001, single addr_ok pulse.
//  4 arready held low 5 cycles -> arvalid stable, araddr stable, no addr_ok until handshake.
//  5 bresp=SLVERR -> data_ok still pulses, FSM returns IDLE, next read proceeds normally.
//  6 assert rst in RD_DATA before rvalid -> all valids/readies low next edge, no data_ok, new req accepted after rst.

Source files
------------

// File: rtl/d_sramlike_axi_bridge_pkg.sv
// Shared definitions for the D-cache SRAM-like to AXI bridge: AXI field
// constants, access sizes, bridge state encodings and byte-strobe helpers.
package d_sramlike_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4
  } bridge_state_e;

  // Byte-lane enables for an access; also shared with the cache write-mask logic.
  function automatic logic [3:0] size_addr_to_strb(input logic [1:0] size,
                                                   input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // The reserved size code 11 is issued as a word transfer.
  function automatic logic [2:0] size_to_axsize(input logic [1:0] size);
    logic [2:0] axsize;
    case (size)
      SIZE_BYTE: axsize = 3'b000;
      SIZE_HALF: axsize = 3'b001;
      default:   axsize = 3'b010;
    endcase
    return axsize;
  endfunction

endpackage

// File: rtl/d_sramlike_axi_bridge.sv
// Single-outstanding, single-beat AXI master fronting the write-back D-cache
// miss/writeback port. One request is latched in IDLE and carried to completion.
module d_sramlike_axi_bridge
  import d_sramlike_axi_bridge_pkg::*;
#(
  parameter int          ID_WIDTH = 4,
  parameter int unsigned AXI_ID   = 1
) (
  input  logic                clk,
  input  logic                rst,
  // cache side
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                addr_ok,
  output logic                data_ok,
  // AR
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  // R
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata_i,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AW
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  // W
  output logic [31:0]         wdata_o,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // B
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  bridge_state_e state_r;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          aw_done_r;
  logic          w_done_r;

  logic          aw_hs_s;
  logic          w_hs_s;
  logic          wr_complete_s;
  logic          unused_s;

  assign aw_hs_s = awvalid & awready;
  assign w_hs_s  = wvalid & wready;
  // The write is accepted on the cycle the later of AW/W completes, whichever order they arrive in.
  assign wr_complete_s = (state_r == ST_WR_ADDR) & (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);

  assign addr_ok = (arvalid & arready) | wr_complete_s;
  assign data_ok = (rvalid & rready) | (bvalid & bready);
  assign rdata   = rdata_i;

  assign arid    = AXI_ID[ID_WIDTH-1:0];
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = size_to_axsize(size_q);
  assign arburst = AXI_BURST_INCR;

  assign awid    = AXI_ID[ID_WIDTH-1:0];
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = size_to_axsize(size_q);
  assign awburst = AXI_BURST_INCR;

  assign wdata_o = wdata_q;
  assign wstrb   = size_addr_to_strb(size_q, addr_q[1:0]);
  assign wlast   = 1'b1;

  // Responses carry no error path and ids are not checked.
  assign unused_s = ^{rid, rresp, rlast, bid, bresp, wr_q};

  // Bridge FSM: request latch, channel valid/ready registers and AW/W completion flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      arvalid   <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      rready    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            wr_q    <= wr;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (wr) begin
              state_r <= ST_WR_ADDR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state_r <= ST_RD_ADDR;
              arvalid <= 1'b1;
            end
          end
        end
        ST_RD_ADDR: begin
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_r <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rvalid && rready) begin
            rready  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WR_ADDR: begin
          if (aw_hs_s) begin
            awvalid   <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid   <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (wr_complete_s) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            bready    <= 1'b1;
            state_r   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid && bready) begin
            bready  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
          arvalid   <= 1'b0;
          awvalid   <= 1'b0;
          wvalid    <= 1'b0;
          rready    <= 1'b0;
          bready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_sramlike_axi_bridge.sv
// Directed bench for d_sramlike_axi_bridge: a transaction-level model checks every
// cycle, and literal latencies/strobes from the test list pin that model.
module tb_d_sramlike_axi_bridge;

  logic        clk, rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, axi_rdata, wdata_o;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int addr_ok_cnt = 0, data_ok_cnt = 0;
  int last_addr_ok_cyc = -1, last_data_ok_cyc = -1;
  logic [31:0] last_rdata = 32'd0;

  d_sramlike_axi_bridge dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_i(axi_rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata_o(wdata_o), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [2:0] m_axsize(input logic [1:0] sz);
    return (sz == 2'd3) ? 3'd2 : {1'b0, sz};
  endfunction

  // Transaction model: at most one request in flight, address phase then response phase.
  logic        m_busy = 1'b0, m_wr = 1'b0, m_addr_phase = 1'b0, m_aw_seen = 1'b0, m_w_seen = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;

  initial begin
    logic e_ar, e_aw, e_w, e_r, e_b, e_aok, e_dok, aw_hs, w_hs;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid",  32'(wvalid),  32'd0);
        chk("rst_rready",  32'(rready),  32'd0);
        chk("rst_bready",  32'(bready),  32'd0);
        chk("rst_addr_ok", 32'(addr_ok), 32'd0);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        m_busy = 1'b0;
      end else begin
        e_ar  = m_busy & ~m_wr & m_addr_phase;
        e_aw  = m_busy & m_wr & m_addr_phase & ~m_aw_seen;
        e_w   = m_busy & m_wr & m_addr_phase & ~m_w_seen;
        e_r   = m_busy & ~m_wr & ~m_addr_phase;
        e_b   = m_busy & m_wr & ~m_addr_phase;
        aw_hs = e_aw & awready;
        w_hs  = e_w & wready;
        e_aok = (e_ar & arready) |
                (m_busy & m_wr & m_addr_phase & (m_aw_seen | aw_hs) & (m_w_seen | w_hs));
        e_dok = (e_r & rvalid) | (e_b & bvalid);
        chk("arvalid", 32'(arvalid), 32'(e_ar));
        chk("awvalid", 32'(awvalid), 32'(e_aw));
        chk("wvalid",  32'(wvalid),  32'(e_w));
        chk("rready",  32'(rready),  32'(e_r));
        chk("bready",  32'(bready),  32'(e_b));
        chk("addr_ok", 32'(addr_ok), 32'(e_aok));
        chk("data_ok", 32'(data_ok), 32'(e_dok));
        chk("rdata",   rdata, axi_rdata);
        if (e_ar) begin
          chk("araddr",  araddr, m_addr);
          chk("arsize",  32'(arsize), 32'(m_axsize(m_size)));
          chk("arlen",   32'(arlen), 32'd0);
          chk("arburst", 32'(arburst), 32'd1);
          chk("arid",    32'(arid), 32'd1);
        end
        if (e_aw) begin
          chk("awaddr",  awaddr, m_addr);
          chk("awsize",  32'(awsize), 32'(m_axsize(m_size)));
          chk("awlen",   32'(awlen), 32'd0);
          chk("awburst", 32'(awburst), 32'd1);
          chk("awid",    32'(awid), 32'd1);
        end
        if (e_w) begin
          chk("wdata_o", wdata_o, m_wdata);
          chk("wstrb",   32'(wstrb), 32'(m_strb(m_size, m_addr)));
          chk("wlast",   32'(wlast), 32'd1);
        end
        if (!m_busy) begin
          if (req) begin
            m_busy = 1'b1; m_wr = wr; m_size = size; m_addr = addr; m_wdata = wdata;
            m_addr_phase = 1'b1; m_aw_seen = 1'b0; m_w_seen = 1'b0;
          end
        end else if (e_aok) begin
          m_addr_phase = 1'b0;
        end else if (e_dok) begin
          m_busy = 1'b0;
        end else begin
          m_aw_seen = m_aw_seen | aw_hs;
          m_w_seen  = m_w_seen | w_hs;
        end
      end
      if (addr_ok === 1'b1) begin
        addr_ok_cnt++;
        last_addr_ok_cyc = cyc;
      end
      if (data_ok === 1'b1) begin
        data_ok_cnt++;
        last_data_ok_cyc = cyc;
        last_rdata = rdata;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int req_cyc, a0, d0;

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; axi_rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rid = 4'd1;
    bvalid = 1'b0; bresp = 2'd0; bid = 4'd1;
    tick(); tick();
    rst = 1'b0;

    // 1: read word, immediate arready, rvalid one cycle later
    tick(); req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h1000_0004; arready = 1'b1; req_cyc = cyc;
    tick();
    tick(); req = 1'b0; rvalid = 1'b1; axi_rdata = 32'hDEADBEEF;
    tick(); rvalid = 1'b0; arready = 1'b0;
    chk("t1_addr_ok_lat", 32'(last_addr_ok_cyc - req_cyc), 32'd1);
    chk("t1_data_ok_lat", 32'(last_data_ok_cyc - req_cyc), 32'd2);
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);

    // 2: write byte at offset 3, AW early, W three cycles later
    tick(); req = 1'b1; wr = 1'b1; size = 2'b00; addr = 32'h2000_0003; wdata = 32'hAA00_0000;
    awready = 1'b1; req_cyc = cyc; a0 = addr_ok_cnt;
    tick();
    tick(); awready = 1'b0;
    tick();
    tick(); wready = 1'b1;
    chk("t2_wstrb", 32'(wstrb), 32'h8);
    chk("t2_wdata_o", wdata_o, 32'hAA00_0000);
    tick(); req = 1'b0; wready = 1'b0; bvalid = 1'b1;
    tick(); bvalid = 1'b0;
    chk("t2_addr_ok_lat", 32'(last_addr_ok_cyc - req_cyc), 32'd4);
    chk("t2_data_ok_lat", 32'(last_data_ok_cyc - req_cyc), 32'd5);
    chk("t2_addr_ok_cnt", 32'(addr_ok_cnt - a0), 32'd1);

    // 3: write half at offset 2, AW and W in the same cycle
    tick(); req = 1'b1; wr = 1'b1; size = 2'b01; addr = 32'h3000_0002; wdata = 32'h1234_0000;
    awready = 1'b1; wready = 1'b1; req_cyc = cyc; a0 = addr_ok_cnt;
    tick();
    chk("t3_wstrb", 32'(wstrb), 32'hC);
    chk("t3_awsize", 32'(awsize), 32'd1);
    tick(); req = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    tick(); bvalid = 1'b0;
    chk("t3_addr_ok_cnt", 32'(addr_ok_cnt - a0), 32'd1);
    chk("t3_data_ok_lat", 32'(last_data_ok_cyc - req_cyc), 32'd2);

    // 4: arready low for 5 cycles, stray rvalid while waiting on AR
    tick(); req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h4000_0008; req_cyc = cyc;
    a0 = addr_ok_cnt; d0 = data_ok_cnt;
    for (int i = 1; i <= 5; i++) begin
      tick(); rvalid = (i == 3); axi_rdata = 32'h7777_7777;
      chk("t4_araddr", araddr, 32'h4000_0008);
    end
    tick(); rvalid = 1'b0; arready = 1'b1;
    chk("t4_no_addr_ok", 32'(addr_ok_cnt - a0), 32'd0);
    chk("t4_no_data_ok", 32'(data_ok_cnt - d0), 32'd0);
    tick(); req = 1'b0; arready = 1'b0; rvalid = 1'b1; axi_rdata = 32'h0BAD_F00D;
    tick(); rvalid = 1'b0;
    chk("t4_addr_ok_lat", 32'(last_addr_ok_cyc - req_cyc), 32'd6);
    chk("t4_data_ok_lat", 32'(last_data_ok_cyc - req_cyc), 32'd7);
    chk("t4_rdata", last_rdata, 32'h0BAD_F00D);

    // 5: size 11 write, W before AW, SLVERR response, then a normal read
    tick(); req = 1'b1; wr = 1'b1; size = 2'b11; addr = 32'h5000_0000; wdata = 32'hCAFE_F00D;
    wready = 1'b1; req_cyc = cyc; d0 = data_ok_cnt;
    tick();
    chk("t5_wstrb", 32'(wstrb), 32'hF);
    chk("t5_awsize", 32'(awsize), 32'd2);
    tick(); wready = 1'b0;
    tick(); awready = 1'b1;
    tick(); req = 1'b0; awready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
    tick(); bvalid = 1'b0; bresp = 2'b00;
    chk("t5_addr_ok_lat", 32'(last_addr_ok_cyc - req_cyc), 32'd3);
    chk("t5_slverr_data_ok", 32'(data_ok_cnt - d0), 32'd1);
    tick(); req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h5000_0010; arready = 1'b1; req_cyc = cyc;
    tick();
    tick(); req = 1'b0; arready = 1'b0; rvalid = 1'b1; axi_rdata = 32'h55AA_55AA;
    tick(); rvalid = 1'b0;
    chk("t5_rd_data_ok_lat", 32'(last_data_ok_cyc - req_cyc), 32'd2);
    chk("t5_rdata", last_rdata, 32'h55AA_55AA);

    // 6: reset while waiting for R, stray rvalid afterwards, then a fresh read
    tick(); req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h6000_0000; arready = 1'b1;
    tick();
    tick(); req = 1'b0; arready = 1'b0; d0 = data_ok_cnt; rst = 1'b1;
    tick(); rst = 1'b0; rvalid = 1'b1; axi_rdata = 32'h1111_1111;
    tick(); rvalid = 1'b0;
    tick();
    chk("t6_no_data_ok", 32'(data_ok_cnt - d0), 32'd0);
    req = 1'b1; addr = 32'h6000_0004; arready = 1'b1; req_cyc = cyc;
    tick();
    tick(); req = 1'b0; arready = 1'b0; rvalid = 1'b1; axi_rdata = 32'h600D_CAFE;
    tick(); rvalid = 1'b0;
    chk("t6_addr_ok_lat", 32'(last_addr_ok_cyc - req_cyc), 32'd1);
    chk("t6_data_ok_lat", 32'(last_data_ok_cyc - req_cyc), 32'd2);
    chk("t6_rdata", last_rdata, 32'h600D_CAFE);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
